// File: rtl/freq_meter.sv
// Frequency meter: measures the period and high time of a slow square wave in clk cycles.
// A rise arms the measurement; each later rise publishes a result held until acknowledged.
// A period longer than TMO cycles drops the meter back to idle and pulses o_timeout.
module freq_meter #(
    parameter int unsigned W   = 16,
    parameter int unsigned TMO = 1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_sig,
    input  logic         i_ack,
    output logic         o_valid,
    output logic [W-1:0] o_period,
    output logic [W-1:0] o_high,
    output logic         o_lock,
    output logic         o_timeout,
    output logic         o_overrun
);

    typedef enum logic [0:0] {StIdle, StMeas} state_e;

    state_e         state_q, state_d;
    logic           s1_q, s2_q, s3_q;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   hi_cap_q, hi_cap_d;
    logic [W-1:0]   period_q, period_d;
    logic [W-1:0]   high_q, high_d;
    logic           valid_q, valid_d;
    logic           lock_q, lock_d;
    logic           timeout_q, timeout_d;
    logic           overrun_q, overrun_d;

    logic           rise, fall, load, tmo_hit, accept;

    // s3 is the delayed copy of s2, so both edge types see the same latency.
    assign rise   = s2_q & ~s3_q;
    assign fall   = ~s2_q & s3_q;
    assign accept = i_ack & valid_q;

    // Synchronizer, edge-delay flop and all measurement state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_cap_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            lock_q    <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            s1_q      <= i_sig;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_cap_q  <= hi_cap_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            lock_q    <= lock_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: FSM, interval counter, result capture and handshake flags.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_cap_d  = hi_cap_q;
        period_d  = period_q;
        high_d    = high_q;
        load      = 1'b0;
        tmo_hit   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StMeas;
                    cnt_d   = W'(1);
                end
            end
            StMeas: begin
                // A rise on the same cycle the count hits TMO still yields a result.
                if (rise) begin
                    load     = 1'b1;
                    cnt_d    = W'(1);
                    period_d = cnt_q;
                    high_d   = hi_cap_q;
                end else if (cnt_q == W'(TMO)) begin
                    tmo_hit = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + W'(1);
                    if (fall) begin
                        hi_cap_d = cnt_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end

        // Overwriting an unacknowledged result wins over a same-cycle clear.
        overrun_d = overrun_q;
        if (load && valid_q && !i_ack) begin
            overrun_d = 1'b1;
        end else if (accept) begin
            overrun_d = 1'b0;
        end

        lock_d = lock_q;
        if (load) begin
            lock_d = 1'b1;
        end else if (tmo_hit) begin
            lock_d = 1'b0;
        end

        timeout_d = tmo_hit;
    end

    assign o_valid   = valid_q;
    assign o_period  = period_q;
    assign o_high    = high_q;
    assign o_lock    = lock_q;
    assign o_timeout = timeout_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: square-wave generator, hand-computed results, one check task.
module tb_freq_meter;

    localparam int unsigned W   = 16;
    localparam int unsigned TMO = 300;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i_sig = 1'b0;
    logic         i_ack = 1'b0;
    logic         o_valid;
    logic [W-1:0] o_period;
    logic [W-1:0] o_high;
    logic         o_lock;
    logic         o_timeout;
    logic         o_overrun;

    int checks   = 0;
    int failures = 0;

    // Generator state: one i_sig sample per clk, gen_high cycles high out of gen_period.
    logic gen_en     = 1'b0;
    logic gen_level  = 1'b0;
    int   gen_period = 100;
    int   gen_high   = 50;
    int   ph         = 0;
    int   tmo_cnt    = 0;
    int   tm0;
    int   lat;

    freq_meter #(
        .W   (W),
        .TMO (TMO)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .i_sig     (i_sig),
        .i_ack     (i_ack),
        .o_valid   (o_valid),
        .o_period  (o_period),
        .o_high    (o_high),
        .o_lock    (o_lock),
        .o_timeout (o_timeout),
        .o_overrun (o_overrun)
    );

    always #5 clk = ~clk;

    // Square-wave source, updated just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (gen_en) begin
            if (ph == gen_period - 1) ph = 0;
            else ph = ph + 1;
            i_sig = (ph < gen_high);
        end else begin
            i_sig = gen_level;
        end
    end

    // Count o_timeout pulse cycles.
    always begin
        @(negedge clk);
        if (o_timeout) tmo_cnt = tmo_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_gen(input int p, input int h);
        gen_period = p;
        gen_high   = h;
        ph         = p - 1;
        gen_en     = 1'b1;
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        gen_en    = 1'b0;
        gen_level = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int bound, output int n);
        n = 0;
        while (!o_valid && n < bound) begin
            @(negedge clk);
            n = n + 1;
        end
        if (!o_valid) check(tag, o_valid, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_period"}, o_period, 0);
        check({tag, "_high"}, o_high, 0);
        check({tag, "_lock"}, o_lock, 0);
        check({tag, "_timeout"}, o_timeout, 0);
        check({tag, "_overrun"}, o_overrun, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        reset_dut();

        // 100/50 with i_ack tied high: first rise only arms, one pulse per period
        i_ack = 1'b1;
        start_gen(100, 50);
        wait_valid("p100_first_wait", 250, lat);
        check("p100_first_after_second_rise", (lat >= 100 && lat <= 106), 1);
        for (int k = 0; k < 3; k++) begin
            check("p100_period", o_period, 100);
            check("p100_high", o_high, 50);
            check("p100_lock", o_lock, 1);
            check("p100_overrun", o_overrun, 0);
            @(negedge clk);
            check("p100_valid_pulse", o_valid, 0);
            wait_valid("p100_wait", 110, lat);
            check("p100_spacing", lat, 99);
        end

        // Minimum high width: 37/1
        reset_dut();
        start_gen(37, 1);
        wait_valid("p37_wait0", 100, lat);
        check("p37_period", o_period, 37);
        check("p37_high", o_high, 1);
        @(negedge clk);
        wait_valid("p37_wait1", 50, lat);
        check("p37_period2", o_period, 37);
        check("p37_high2", o_high, 1);

        // Overrun: no ack across two results, then one ack clears both flags
        reset_dut();
        i_ack = 1'b0;
        start_gen(20, 10);
        wait_valid("ovr_wait", 60, lat);
        check("ovr_period", o_period, 20);
        check("ovr_high", o_high, 10);
        check("ovr_flag_first", o_overrun, 0);
        repeat (21) @(negedge clk);
        check("ovr_valid_held", o_valid, 1);
        check("ovr_flag_set", o_overrun, 1);
        check("ovr_period2", o_period, 20);
        i_ack = 1'b1;
        @(negedge clk);
        i_ack = 1'b0;
        check("ovr_ack_valid", o_valid, 0);
        check("ovr_ack_flag", o_overrun, 0);

        // Timeout: i_sig held high after a result; result kept, lock dropped
        reset_dut();
        i_ack = 1'b0;
        start_gen(100, 50);
        wait_valid("tmo_wait_res", 250, lat);
        check("tmo_res_period", o_period, 100);
        gen_level = 1'b1;
        gen_en    = 1'b0;
        tm0 = tmo_cnt;
        lat = 0;
        while (!o_timeout && lat < 400) begin
            @(negedge clk);
            lat = lat + 1;
        end
        // cnt is 1 on the cycle o_valid appears; the registered pulse follows cnt==TMO
        check("tmo_latency", lat, TMO);
        check("tmo_lock", o_lock, 0);
        check("tmo_valid_kept", o_valid, 1);
        check("tmo_period_kept", o_period, 100);
        check("tmo_high_kept", o_high, 50);
        @(negedge clk);
        check("tmo_pulse_end", o_timeout, 0);
        repeat (3) @(negedge clk);
        check("tmo_pulse_count", tmo_cnt - tm0, 1);
        i_ack = 1'b1;
        @(negedge clk);
        check("tmo_acked", o_valid, 0);
        gen_level = 1'b0;
        repeat (5) @(negedge clk);
        start_gen(100, 50);
        wait_valid("tmo_rearm_wait", 250, lat);
        check("tmo_rearm_no_result", (lat >= 100 && lat <= 106), 1);
        check("tmo_relock", o_lock, 1);

        // Reset 40 cycles into a period (signal low then): two further rises needed
        reset_dut();
        i_ack = 1'b1;
        start_gen(100, 30);
        wait_valid("mid_wait0", 250, lat);
        check("mid_period0", o_period, 100);
        check("mid_high0", o_high, 30);
        repeat (36) @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("mid_rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_valid("mid_wait1", 300, lat);
        check("mid_two_rises", (lat >= 150 && lat <= 170), 1);
        check("mid_period1", o_period, 100);
        check("mid_high1", o_high, 30);

        // Period exactly TMO: rise wins over timeout
        reset_dut();
        i_ack = 1'b1;
        tm0 = tmo_cnt;
        start_gen(TMO, 100);
        wait_valid("edge_wait", 700, lat);
        check("edge_period", o_period, TMO);
        check("edge_high", o_high, 100);
        check("edge_lock", o_lock, 1);
        repeat (3) @(negedge clk);
        check("edge_no_timeout", tmo_cnt - tm0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the width of the counter and result fields.
REQ-002 The block SHALL have parameter TMO, default 1000, giving the timeout in clk cycles without a rising edge of i_sig; legal range 2..2^W-1.
REQ-003 Port clk, input, 1 bit: the single system clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port i_sig, input, 1 bit: the slow square wave to be measured, asynchronous to clk.
REQ-006 Port i_ack, input, 1 bit: consumer acknowledge of the current result.
REQ-007 Port o_valid, output, 1 bit: o_period and o_high hold an unacknowledged result.
REQ-008 Port o_period, output, W bits: rising-to-rising interval of i_sig, in clk cycles.
REQ-009 Port o_high, output, W bits: rising-to-falling interval of i_sig, in clk cycles.
REQ-010 Port o_lock, output, 1 bit: at least one full period has been measured since the last reset or timeout.
REQ-011 Port o_timeout, output, 1 bit: one-cycle pulse when a timeout occurs.
REQ-012 Port o_overrun, output, 1 bit: sticky flag, set when an unacknowledged result is overwritten.

Function
REQ-013 i_sig SHALL pass through a 2-flop synchronizer (s1, s2) and then a delay flop s3.
REQ-014 A rise SHALL be detected on the cycle where s2=1 and s3=0; a fall SHALL be detected where s2=0 and s3=1.
REQ-015 The detection latency from an i_sig transition to the rise/fall cycle SHALL be 2-3 clk cycles, and equal for both edge types.
REQ-016 The FSM SHALL have two states, IDLE and MEAS; the reset state SHALL be IDLE.
REQ-017 In IDLE, a rise SHALL move the FSM to MEAS, set cnt to 1, and produce no result; a fall SHALL be ignored.
REQ-018 In MEAS, on every cycle without a rise, cnt SHALL increment by 1.
REQ-019 In MEAS, a fall SHALL capture hi_cap <= cnt.
REQ-020 In MEAS, a rise SHALL load o_period <= cnt and o_high <= hi_cap, set o_valid and o_lock the next cycle, and reset cnt to 1.
REQ-021 Given rises on cycles t0 and t1 and a fall on cycle tf, the result SHALL be o_period = t1-t0 and o_high = tf-t0.
REQ-022 When cnt reaches TMO in MEAS without a rise, the FSM SHALL go to IDLE, pulse o_timeout for exactly 1 cycle, and clear o_lock.
REQ-023 A timeout SHALL leave o_valid, o_period and o_high unchanged.
REQ-024 If a rise occurs on the same cycle cnt reaches TMO, the rise SHALL take priority: a result is produced and there is no timeout.
REQ-025 cnt SHALL never wrap; TMO <= 2^W-1 guarantees this.
REQ-026 o_valid SHALL remain high until a cycle with i_ack=1 and o_valid=1, after which it SHALL clear on the next cycle.
REQ-027 o_period and o_high SHALL be stable while o_valid=1, except when overwritten under REQ-028.
REQ-028 A new result while o_valid=1 and i_ack=0 SHALL overwrite the outputs, keep o_valid=1, and set o_overrun.
REQ-029 A new result on the same cycle as i_ack=1 SHALL load the outputs, keep o_valid=1, and not set o_overrun.
REQ-030 o_overrun SHALL clear on any cycle with an accepted i_ack unless it is being set on that cycle; set SHALL take priority.
REQ-031 i_ack while o_valid=0 SHALL have no effect.

Reset
REQ-032 When reset=1, the block SHALL immediately clear s1, s2, s3, cnt, hi_cap, o_period, o_high, o_valid, o_lock, o_timeout and o_overrun to 0, and force the FSM to IDLE.
REQ-033 Reset asserted mid-measurement SHALL discard the partial period.
REQ-034 After reset is released, the first rise SHALL only arm the FSM (IDLE to MEAS) and produce no result.

Verification
REQ-035 i_sig period 100 clk with 50 clk high, i_ack tied to 1 -> from the second rise onward, one o_valid pulse per period with o_period=100, o_high=50; o_lock=1.
REQ-036 Period 37, high 1 clk (minimum width held for one full clk) -> o_period=37, o_high=1.
REQ-037 i_ack=0 across two results (period 20) -> second result overwrites, o_overrun=1; then i_ack=1 -> o_valid=0 and o_overrun=0 the next cycle.
REQ-038 TMO=300, i_sig held high after one rise -> o_timeout pulses once, 300 cycles after the rise; o_lock=0; the next rise produces no result.
REQ-039 reset pulsed 40 cycles into a 100-cycle period -> all outputs 0 immediately, and the first result appears only after two further rises.
REQ-040 Rise coincident with cnt=TMO (period exactly TMO) -> o_period=TMO, o_valid=1, and no o_timeout pulse.
